// File: rtl/aud_serial_if.sv
// I2S codec serial interface: ADC capture and DAC playback with the codec as bit-clock master.
// Define AUD_LOOPBACK_EN to route every captured ADC frame straight into the playback holding register.
module aud_serial_if #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             aud_bclk,
  input  logic             aud_adclrck,
  input  logic             aud_adcdat,
  input  logic             aud_daclrck,
  output logic             aud_dacdat,
  output logic [WIDTH-1:0] adc_left,
  output logic [WIDTH-1:0] adc_right,
  output logic             adc_valid,
  input  logic [WIDTH-1:0] dac_left,
  input  logic [WIDTH-1:0] dac_right,
  input  logic             dac_valid,
  output logic             dac_ready,
  output logic             underrun,
  output logic             frame_err
);

  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    DELAY,
    SHIFT,
    PAD
  } tx_state_e;

  // Codec pins in one bundle: {adcdat, daclrck, adclrck, bclk}
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [2:0]                  prev_q;
  logic [FW-1:0]               fill_q;
  logic [3:0]                  pins;
  logic [3:0]                  sync_o;
  logic                        live;
  logic                        bclk_rise;
  logic                        bclk_fall;
  logic                        adc_edge;
  logic                        dac_rise;
  logic                        dac_fall;
  logic                        adc_dat;

  assign pins   = {aud_adcdat, aud_daclrck, aud_adclrck, aud_bclk};
  assign sync_o = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      prev_q <= sync_o[2:0];
      if (fill_q != FILL_DONE) fill_q <= fill_q + FW'(1);
    end
  end

  // Edges are trusted only once the edge register holds a real pin level
  assign live      = (fill_q == FILL_DONE);
  assign bclk_rise = live & sync_o[0] & ~prev_q[0];
  assign bclk_fall = live & ~sync_o[0] & prev_q[0];
  assign adc_edge  = live & (sync_o[1] ^ prev_q[1]);
  assign dac_rise  = live & sync_o[2] & ~prev_q[2];
  assign dac_fall  = live & ~sync_o[2] & prev_q[2];
  assign adc_dat   = sync_o[3];

  logic             rx_armed_q, rx_armed_d;
  logic             rx_skip_q, rx_skip_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic             rx_chan_q, rx_chan_d;
  logic             left_ok_q, left_ok_d;
  logic [WIDTH-1:0] left_hold_q, left_hold_d;
  logic [WIDTH-1:0] adc_left_q, adc_left_d;
  logic [WIDTH-1:0] adc_right_q, adc_right_d;
  logic             adc_valid_q, adc_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] rx_word;

  assign rx_word = {rx_sr_q[WIDTH-2:0], adc_dat};

  always_comb begin
    rx_armed_d  = rx_armed_q;
    rx_skip_d   = rx_skip_q;
    rx_cnt_d    = rx_cnt_q;
    rx_sr_d     = rx_sr_q;
    rx_chan_d   = rx_chan_q;
    left_ok_d   = left_ok_q;
    left_hold_d = left_hold_q;
    adc_left_d  = adc_left_q;
    adc_right_d = adc_right_q;
    adc_valid_d = 1'b0;
    frame_err_d = frame_err_q;
    if (!enable) begin
      rx_armed_d = 1'b0;
      rx_skip_d  = 1'b0;
      rx_cnt_d   = '0;
      left_ok_d  = 1'b0;
    end else if (adc_edge) begin
      if (rx_armed_q && rx_cnt_q != CNT_FULL) begin
        frame_err_d = 1'b1;
        left_ok_d   = 1'b0;
      end
      rx_armed_d = 1'b1;
      rx_skip_d  = 1'b1;
      rx_cnt_d   = '0;
      rx_chan_d  = sync_o[1];
      if (!sync_o[1]) left_ok_d = 1'b0;
    end else if (bclk_rise && rx_armed_q) begin
      if (rx_skip_q) begin
        rx_skip_d = 1'b0;
      end else if (rx_cnt_q != CNT_FULL) begin
        rx_sr_d  = rx_word;
        rx_cnt_d = rx_cnt_q + CW'(1);
        if (rx_cnt_q == CNT_LAST) begin
          if (!rx_chan_q) begin
            left_hold_d = rx_word;
            left_ok_d   = 1'b1;
          end else if (left_ok_q) begin
            adc_left_d  = left_hold_q;
            adc_right_d = rx_word;
            adc_valid_d = 1'b1;
            left_ok_d   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_armed_q  <= 1'b0;
      rx_skip_q   <= 1'b0;
      rx_cnt_q    <= '0;
      rx_sr_q     <= '0;
      rx_chan_q   <= 1'b0;
      left_ok_q   <= 1'b0;
      left_hold_q <= '0;
      adc_left_q  <= '0;
      adc_right_q <= '0;
      adc_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_armed_q  <= rx_armed_d;
      rx_skip_q   <= rx_skip_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_sr_q     <= rx_sr_d;
      rx_chan_q   <= rx_chan_d;
      left_ok_q   <= left_ok_d;
      left_hold_q <= left_hold_d;
      adc_left_q  <= adc_left_d;
      adc_right_q <= adc_right_d;
      adc_valid_q <= adc_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  tx_state_e        tx_state_q;
  logic [WIDTH-1:0] tx_word_q;
  logic [WIDTH-1:0] tx_right_q;
  logic [CW-1:0]    tx_cnt_q;
  logic             dacdat_q;
  logic             underrun_q;

  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             ready_q, ready_d;
  logic             frame_load;

  assign frame_load = enable & dac_fall & (tx_state_q != IDLE);

`ifdef AUD_LOOPBACK_EN
  logic unused_dac;
  assign unused_dac = ^{dac_valid, dac_left, dac_right};
`else
  logic xfer;
  assign xfer = dac_valid & dac_ready;
`endif

  // A frame load and a refill in the same cycle leave the register full
  always_comb begin
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    if (!enable) begin
      hold_full_d = 1'b0;
      hold_l_d    = '0;
      hold_r_d    = '0;
    end else begin
      if (frame_load) hold_full_d = 1'b0;
`ifdef AUD_LOOPBACK_EN
      if (adc_valid_q) begin
        hold_full_d = 1'b1;
        hold_l_d    = adc_left_q;
        hold_r_d    = adc_right_q;
      end
`else
      if (xfer) begin
        hold_full_d = 1'b1;
        hold_l_d    = dac_left;
        hold_r_d    = dac_right;
      end
`endif
    end
`ifdef AUD_LOOPBACK_EN
    ready_d = 1'b0;
`else
    ready_d = ~hold_full_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      ready_q     <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_word_q  <= '0;
      tx_right_q <= '0;
      tx_cnt_q   <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (!enable) begin
        tx_state_q <= IDLE;
        tx_cnt_q   <= '0;
        dacdat_q   <= 1'b0;
      end else if (tx_state_q == IDLE) begin
        tx_state_q <= WAIT_FRAME;
      end else if (dac_fall) begin
        tx_state_q <= DELAY;
        tx_cnt_q   <= '0;
        dacdat_q   <= 1'b0;
        tx_word_q  <= hold_full_q ? hold_l_q : '0;
        tx_right_q <= hold_full_q ? hold_r_q : '0;
        underrun_q <= ~hold_full_q;
      end else if (dac_rise && tx_state_q != WAIT_FRAME) begin
        tx_state_q <= DELAY;
        tx_cnt_q   <= '0;
        dacdat_q   <= 1'b0;
        tx_word_q  <= tx_right_q;
      end else if (bclk_fall) begin
        unique case (tx_state_q)
          DELAY, SHIFT: begin
            if (tx_cnt_q != CNT_FULL) begin
              tx_state_q <= SHIFT;
              dacdat_q   <= tx_word_q[WIDTH-1];
              tx_word_q  <= tx_word_q << 1;
              tx_cnt_q   <= tx_cnt_q + CW'(1);
            end else begin
              tx_state_q <= PAD;
              dacdat_q   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign aud_dacdat = dacdat_q;
  assign adc_left   = adc_left_q;
  assign adc_right  = adc_right_q;
  assign adc_valid  = adc_valid_q;
  assign dac_ready  = ready_q & enable;
  assign underrun   = underrun_q;
  assign frame_err  = frame_err_q;

endmodule
